calc_controller: RTL and testbench

//  Sequencer for the calculator datapath. Consumes the 4-bit scan code from the keypad scanner.

---
 rtl/calc_controller_if.sv | 22 ++
 rtl/calc_controller.sv | 150 +++++++++++++++
 tb/tb_calc_controller.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/calc_controller_if.sv
// Keypad-to-display bundle for the calculator sequencer.
// The slave side is the controller. The master side is the keypad/display environment.
interface calc_controller_if #(
   parameter int W = 16
) ();
   logic [3:0]   key;
   logic [W-1:0] disp_mag;
   logic         disp_neg;
   logic         disp_err;
   logic [1:0]   op_pend;
   logic         key_evt;

   modport slave (
      input  key,
      output disp_mag, disp_neg, disp_err, op_pend, key_evt
   );

   modport master (
      output key,
      input  disp_mag, disp_neg, disp_err, op_pend, key_evt
   );
endinterface

// File: rtl/calc_controller.sv
// Calculator sequencer.
// Turns keypad scan codes into discrete key events and runs digit entry, +/-, =, repeat-= and
// CLEAR on signed operands. It drives a magnitude/sign/error triple to the display path.
module calc_controller #(
   parameter int DIGITS = 4,
   parameter int W      = 16
) (
   input  logic            CLK2MHZ,
   input  logic            rst_n,
   calc_controller_if.slave bus
);
   localparam int CW = $clog2(DIGITS + 1);
   localparam logic signed [W-1:0] MAXV  = W'(10**DIGITS - 1);
   localparam logic signed [W-1:0] NMAXV = -MAXV;

   typedef enum logic [2:0] {S_ENTRY_A, S_OP, S_ENTRY_B, S_RESULT, S_ERROR} state_t;
   typedef enum logic [1:0] {OP_NONE = 2'b00, OP_ADD = 2'b01, OP_SUB = 2'b10} op_t;

   state_t                st, st_n;
   op_t                   op, op_n, key_op;
   logic signed [W-1:0]   a, a_n, b, b_n;
   logic        [CW-1:0]  cnt, cnt_n;
   logic        [3:0]     key_q;
   logic                  evt;
   logic                  is_dig, is_op, is_eq, is_clr;
   logic signed [W-1:0]   d, a_app, b_app, r, show;
   logic                  ovf;

   // Key event detection, operand arithmetic and next-state selection
   always_comb begin
      evt    = (key_q == 4'hD) && (bus.key != 4'hD) && (bus.key != 4'hE);
      is_dig = (bus.key <= 4'd9);
      is_op  = (bus.key == 4'hA) || (bus.key == 4'hB);
      is_eq  = (bus.key == 4'hC);
      is_clr = (bus.key == 4'hF);
      key_op = (bus.key == 4'hB) ? OP_SUB : OP_ADD;
      d      = signed'({{(W-4){1'b0}}, bus.key});
      a_app  = (a <<< 3) + (a <<< 1) + d;
      b_app  = (b <<< 3) + (b <<< 1) + d;
      r      = (op == OP_SUB) ? (a - b) : (op == OP_ADD) ? (a + b) : a;
      ovf    = (r > MAXV) || (r < NMAXV);

      st_n  = st;
      a_n   = a;
      b_n   = b;
      cnt_n = cnt;
      op_n  = op;

      if (evt) begin
         if (is_clr) begin
            st_n  = S_ENTRY_A;
            a_n   = '0;
            b_n   = '0;
            cnt_n = '0;
            op_n  = OP_NONE;
         end else begin
            case (st)
               S_ENTRY_A: begin
                  if (is_dig && (cnt < CW'(DIGITS))) begin
                     a_n   = a_app;
                     cnt_n = cnt + CW'(1);
                  end else if (is_op) begin
                     op_n = key_op;
                     st_n = S_OP;
                  end
               end
               S_OP: begin
                  if (is_dig) begin
                     b_n   = d;
                     cnt_n = CW'(1);
                     st_n  = S_ENTRY_B;
                  end else if (is_op) begin
                     op_n = key_op;
                  end
               end
               S_ENTRY_B: begin
                  if (is_dig && (cnt < CW'(DIGITS))) begin
                     b_n   = b_app;
                     cnt_n = cnt + CW'(1);
                  end else if (is_op || is_eq) begin
                     if (ovf) begin
                        st_n = S_ERROR;
                     end else begin
                        a_n = r;
                        if (is_op) begin
                           op_n = key_op;
                           st_n = S_OP;
                        end else begin
                           st_n = S_RESULT;
                        end
                     end
                  end
               end
               S_RESULT: begin
                  if (is_dig) begin
                     a_n   = d;
                     cnt_n = CW'(1);
                     op_n  = OP_NONE;
                     st_n  = S_ENTRY_A;
                  end else if (is_op) begin
                     op_n = key_op;
                     st_n = S_OP;
                  end else if (is_eq) begin
                     if (ovf) st_n = S_ERROR;
                     else     a_n  = r;
                  end
               end
               default: ;
            endcase
         end
      end

      show = (st_n == S_ENTRY_B) ? b_n : a_n;
   end

   // Sequencer state, key history and registered display outputs
   always_ff @(posedge CLK2MHZ or negedge rst_n) begin
      if (!rst_n) begin
         st           <= S_ENTRY_A;
         a            <= '0;
         b            <= '0;
         cnt          <= '0;
         op           <= OP_NONE;
         key_q        <= 4'hD;
         bus.disp_mag <= '0;
         bus.disp_neg <= 1'b0;
         bus.disp_err <= 1'b0;
         bus.op_pend  <= 2'b00;
         bus.key_evt  <= 1'b0;
      end else begin
         st          <= st_n;
         a           <= a_n;
         b           <= b_n;
         cnt         <= cnt_n;
         op          <= op_n;
         key_q       <= bus.key;
         bus.key_evt <= evt;
         bus.op_pend <= op_n;
         if (st_n == S_ERROR) begin
            bus.disp_err <= 1'b1;
            bus.disp_neg <= 1'b0;
            bus.disp_mag <= '0;
         end else begin
            bus.disp_err <= 1'b0;
            bus.disp_neg <= show[W-1];
            bus.disp_mag <= show[W-1] ? unsigned'(-show) : unsigned'(show);
         end
      end
   end
endmodule

// File: tb/tb_calc_controller.sv
// Directed test of the calculator sequencer against hand-computed display values.
module tb_calc_controller;
   logic clk;
   logic rst_n;
   int   n_assert = 0;
   int   n_fail   = 0;
   int   evt_cnt  = 0;
   int   base;

   calc_controller_if #(.W(16)) bus ();

   calc_controller #(.DIGITS(4), .W(16)) dut (
      .CLK2MHZ (clk),
      .rst_n   (rst_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count key_evt pulses seen on rising edges
   always @(posedge clk) if (bus.key_evt === 1'b1) evt_cnt <= evt_cnt + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic disp(input string tag, input int mag, input bit neg, input bit err);
      check({tag, "_mag"}, 32'(bus.disp_mag), 32'(mag));
      check({tag, "_neg"}, 32'(bus.disp_neg), 32'(neg));
      check({tag, "_err"}, 32'(bus.disp_err), 32'(err));
   endtask

   // Press one key for two cycles, then release to D; optionally check the event pulse
   task automatic press(input logic [3:0] k, input bit chk);
      @(negedge clk) bus.key = k;
      @(negedge clk);
      if (chk) check("evt_pulse", 32'(bus.key_evt), 32'd1);
      @(negedge clk);
      if (chk) check("evt_single", 32'(bus.key_evt), 32'd0);
      bus.key = 4'hD;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      rst_n   = 1'b0;
      bus.key = 4'hD;
      repeat (3) @(negedge clk);
      disp("reset", 0, 1'b0, 1'b0);
      check("reset_op", 32'(bus.op_pend), 32'd0);
      check("reset_evt", 32'(bus.key_evt), 32'd0);
      rst_n = 1'b1;

      // 1: three digits
      base = evt_cnt;
      press(4'h1, 1); press(4'h2, 1); press(4'h3, 1);
      disp("t1", 123, 1'b0, 1'b0);
      check("t1_evts", 32'(evt_cnt - base), 32'd3);

      // 2: fifth digit ignored
      press(4'hF, 1);
      press(4'h1, 1); press(4'h2, 1); press(4'h3, 1); press(4'h4, 1); press(4'h5, 1);
      disp("t2", 1234, 1'b0, 1'b0);

      // 3: subtraction to negative, repeat-=, then a digit restarts a
      press(4'hF, 1);
      press(4'h1, 1); press(4'h2, 1); press(4'hB, 1);
      check("t3_op", 32'(bus.op_pend), 32'd2);
      press(4'h3, 1);
      disp("t3_b3", 3, 1'b0, 1'b0);
      press(4'h0, 1); press(4'hC, 1);
      disp("t3_eq", 18, 1'b1, 1'b0);
      press(4'hC, 1);
      disp("t3_rep", 48, 1'b1, 1'b0);
      press(4'h5, 1);
      disp("t3_dig", 5, 1'b0, 1'b0);
      check("t3_opnone", 32'(bus.op_pend), 32'd0);

      // 4: chaining
      press(4'hF, 1);
      press(4'h5, 1); press(4'hA, 1); press(4'h3, 1); press(4'hA, 1);
      disp("t4_chain", 8, 1'b0, 1'b0);
      check("t4_op", 32'(bus.op_pend), 32'd1);
      press(4'h2, 1); press(4'hC, 1);
      disp("t4_eq", 10, 1'b0, 1'b0);

      // 5: overflow, ignored keys, CLEAR recovery
      press(4'hF, 1);
      press(4'h9, 1); press(4'h9, 1); press(4'h9, 1); press(4'h9, 1);
      press(4'hA, 1); press(4'h1, 1); press(4'hC, 1);
      disp("t5_err", 0, 1'b0, 1'b1);
      press(4'h7, 0); press(4'hC, 0);
      disp("t5_ign", 0, 1'b0, 1'b1);
      press(4'hF, 1);
      disp("t5_clr", 0, 1'b0, 1'b0);
      press(4'h4, 1);
      disp("t5_entry", 4, 1'b0, 1'b0);

      // Boundaries: exactly -MAXV valid, -MAXV - MAXV errors, exactly +MAXV valid
      press(4'hF, 1);
      press(4'h0, 1); press(4'hB, 1);
      press(4'h9, 1); press(4'h9, 1); press(4'h9, 1); press(4'h9, 1); press(4'hC, 1);
      disp("b_negmax", 9999, 1'b1, 1'b0);
      press(4'hB, 1);
      press(4'h9, 1); press(4'h9, 1); press(4'h9, 1); press(4'h9, 1); press(4'hC, 1);
      disp("b_negovf", 0, 1'b0, 1'b1);
      press(4'hF, 1);
      press(4'h9, 1); press(4'h9, 1); press(4'h9, 1); press(4'h8, 1);
      press(4'hA, 1); press(4'h1, 1); press(4'hC, 1);
      disp("b_posmax", 9999, 1'b0, 1'b0);

      // Leading zeros count toward the digit limit
      press(4'hF, 1);
      press(4'h0, 1); press(4'h0, 1); press(4'h0, 1); press(4'h1, 1); press(4'h2, 1);
      disp("b_lead0", 1, 1'b0, 1'b0);

      // Direct change between valid codes is not an event
      press(4'hF, 1);
      base = evt_cnt;
      @(negedge clk) bus.key = 4'h1;
      repeat (3) @(negedge clk);
      bus.key = 4'h2;
      repeat (3) @(negedge clk);
      bus.key = 4'hD;
      repeat (2) @(negedge clk);
      check("b_direct_evts", 32'(evt_cnt - base), 32'd1);
      disp("b_direct", 1, 1'b0, 1'b0);

      // 6: long hold gives one event, then async reset mid-entry
      press(4'hF, 1);
      base = evt_cnt;
      @(negedge clk) bus.key = 4'h7;
      repeat (1000) @(negedge clk);
      bus.key = 4'hD;
      repeat (2) @(negedge clk);
      check("t6_hold_evts", 32'(evt_cnt - base), 32'd1);
      disp("t6_hold", 7, 1'b0, 1'b0);
      press(4'h3, 1);
      disp("t6_pre", 73, 1'b0, 1'b0);
      press(4'hB, 1);
      @(negedge clk) bus.key = 4'h2;
      #2 rst_n = 1'b0;
      #1;
      disp("t6_async", 0, 1'b0, 1'b0);
      check("t6_async_op", 32'(bus.op_pend), 32'd0);
      check("t6_async_evt", 32'(bus.key_evt), 32'd0);
      bus.key = 4'hD;
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
